// File: rtl/hazard_stall_unit.sv
// Hazard detection and front-end stall control for the in-order pipeline.
// Catches the hazards forwarding cannot cover:
// - load-use against EX
// - an ID-stage branch compare waiting on a load in MEM
// - HI/LO reads or new mult/div issues while the mult/div unit is busy
// It owns the mult/div busy counter and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   IF_ID_*              register numbers and class flags of the instruction in ID
//   ID_EX_Rdest/memR     destination and load flag of the instruction in EX
//   EX_MEM_Rd/memR       destination and load flag of the instruction in MEM
//   PC_write/IF_ID_write front-end update enables (low while stalling)
//   ID_EX_flush          inject a bubble into ID_EX
//   md_accept            mult/div in ID issues this cycle
//   md_busy/md_done      mult/div occupancy and HI/LO-written pulse
//   hazard_cause         00 none, 01 load-use, 10 branch-load, 11 mult/div
//   stall_cnt            saturating count of stall cycles
module hazard_stall_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_useRs,
  input  logic             IF_ID_useRt,
  input  logic             IF_ID_branch,
  input  logic             IF_ID_hilo_rd,
  input  logic             IF_ID_md_issue,
  input  logic [4:0]       ID_EX_Rdest,
  input  logic             ID_EX_memR,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_memR,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_flush,
  output logic             md_accept,
  output logic             md_busy,
  output logic             md_done,
  output logic [1:0]       hazard_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] MdLoad = 4'(MD_LATENCY);

  logic [3:0]       md_count_q, md_count_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use, br_load, md_haz, stall;

  // $0 is hard-wired, so it can never be the subject of a hazard.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] dest);
    return use_src && (dest != 5'd0) && (dest == src);
  endfunction

  assign md_busy = (md_count_q != 4'd0);
  // An op abandoned by reset must not report completion.
  assign md_done = !rst && (md_count_q == 4'd1);

  always_comb begin
    load_use = ID_EX_memR &&
               (src_hit(IF_ID_useRs, IF_ID_Rs, ID_EX_Rdest) ||
                src_hit(IF_ID_useRt, IF_ID_Rt, ID_EX_Rdest));
    // A branch on a load still in EX is already held by load_use; this term
    // supplies the second stall cycle once the load reaches MEM.
    br_load  = IF_ID_branch && EX_MEM_memR &&
               (src_hit(IF_ID_useRs, IF_ID_Rs, EX_MEM_Rd) ||
                src_hit(IF_ID_useRt, IF_ID_Rt, EX_MEM_Rd));
    // Includes the md_done cycle: HI/LO is only readable on the cycle after.
    md_haz   = md_busy && (IF_ID_hilo_rd || IF_ID_md_issue);
    stall    = !rst && (load_use || br_load || md_haz);
  end

  always_comb begin
    hazard_cause = 2'b00;
    if (rst)           hazard_cause = 2'b00;
    else if (load_use) hazard_cause = 2'b01;
    else if (br_load)  hazard_cause = 2'b10;
    else if (md_haz)   hazard_cause = 2'b11;
  end

  assign PC_write    = !stall;
  assign IF_ID_write = !stall;
  assign ID_EX_flush = stall;
  assign md_accept   = IF_ID_md_issue && !stall && !rst;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    md_count_d  = md_count_q;
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      md_count_d  = 4'd0;
      stall_cnt_d = '0;
    end else begin
      if (md_accept)               md_count_d = MdLoad;
      else if (md_count_q != 4'd0) md_count_d = md_count_q - 4'd1;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    md_count_q  <= md_count_d;
    stall_cnt_q <= stall_cnt_d;
  end

endmodule
